// File: rtl/seq_mult_booth_pkg.sv
// Shared types for the radix-2 Booth sequential multiplier:
// controller state encoding, Booth operation codes and the recoding helper.
package seq_mult_pkg;

    // One-hot controller states
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    // Accumulator action selected by the Booth recoder
    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the pair {Q[0], q_-1}
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b10:   op = BOOTH_SUB;
            2'b01:   op = BOOTH_ADD;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_mult_booth_if.sv
// Operand/result handshake bundle of the sequential Booth multiplier.
// The multiplier is the slave; the producer/consumer side is the master.
interface seq_mult_booth_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, multiplicand, multiplier, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/seq_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the extended
// multiplicand into the accumulator, then arithmetic right shift of
// {A, Q, q_-1}. The accumulator is two bits wider than an operand so the
// add/subtract cannot overflow for any operand in either mode.
module seq_mult_booth_step
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH:0]   q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m_ext,
    output logic [WIDTH+1:0] acc_next,
    output logic [WIDTH:0]   q_next,
    output logic             q_m1_next
);

    logic [WIDTH+1:0] m_wide_s;
    logic [WIDTH+1:0] sum_s;
    booth_op_t        op_s;

    assign m_wide_s = {m_ext[WIDTH], m_ext};
    assign op_s     = booth_decode({q[0], q_m1});

    // Add, subtract or pass the accumulator according to the Booth pair
    always_comb begin
        sum_s = acc;
        case (op_s)
            BOOTH_ADD: sum_s = acc + m_wide_s;
            BOOTH_SUB: sum_s = acc - m_wide_s;
            BOOTH_NOP: sum_s = acc;
            default:   sum_s = acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {A, Q, q_-1}
    always_comb begin
        acc_next  = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
        q_next    = {sum_s[0], q[WIDTH:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/seq_mult_booth.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, one Booth step per cycle.
// Operands are widened to WIDTH+1 bits (sign- or zero-extended per
// is_signed) so one signed Booth datapath serves both modes; WIDTH+1 steps
// later the low 2*WIDTH bits of {A, Q} hold the exact product.
module seq_mult_booth
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    seq_mult_booth_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t               state_r;
    state_t               state_n_s;
    logic                 load_s;
    logic                 step_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH:0]       m_r;
    logic [WIDTH+1:0]     acc_r;
    logic [WIDTH:0]       q_r;
    logic                 qm1_r;
    logic [2*WIDTH-1:0]   product_r;
    logic [WIDTH:0]       m_load_s;
    logic [WIDTH:0]       q_load_s;
    logic [WIDTH+1:0]     acc_n_s;
    logic [WIDTH:0]       q_n_s;
    logic                 qm1_n_s;

    seq_mult_booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc       (acc_r),
        .q         (q_r),
        .q_m1      (qm1_r),
        .m_ext     (m_r),
        .acc_next  (acc_n_s),
        .q_next    (q_n_s),
        .q_m1_next (qm1_n_s)
    );

    // Handshake and status; in_ready held low while reset is asserted
    assign bus.in_ready  = reset_n &
                           ((state_r == IDLE) | ((state_r == DONE) & bus.out_ready));
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r == RUN) | (state_r == DONE);
    assign bus.product   = product_r;

    // Operand widening; the mode is folded into the extension bit here
    always_comb begin
        if (bus.is_signed) begin
            m_load_s = {bus.multiplicand[WIDTH-1], bus.multiplicand};
            q_load_s = {bus.multiplier[WIDTH-1], bus.multiplier};
        end else begin
            m_load_s = {1'b0, bus.multiplicand};
            q_load_s = {1'b0, bus.multiplier};
        end
    end

    // Controller next-state, operand load and step enables
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        step_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n_s = RUN;
                    load_s    = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_n_s = RUN;
                        load_s    = 1'b1;
                    end else begin
                        state_n_s = IDLE;
                    end
                end else begin
                    state_n_s = DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Booth datapath, step counter and registered product
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= '0;
            m_r       <= '0;
            acc_r     <= '0;
            q_r       <= '0;
            qm1_r     <= 1'b0;
            product_r <= '0;
        end else if (load_s) begin
            cnt_r <= CNT_LOAD;
            m_r   <= m_load_s;
            acc_r <= '0;
            q_r   <= q_load_s;
            qm1_r <= 1'b0;
        end else if (step_s) begin
            cnt_r <= cnt_r - CNT_LAST;
            acc_r <= acc_n_s;
            q_r   <= q_n_s;
            qm1_r <= qm1_n_s;
            if (cnt_r == CNT_LAST) begin
                product_r <= {acc_n_s[WIDTH-2:0], q_n_s};
            end else begin
                product_r <= product_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_seq_mult_booth.sv
// Directed bench for seq_mult_booth: 8-bit vector table, backpressure,
// asynchronous abort, and an exhaustive 4-bit sweep against an integer model.
module tb_seq_mult_booth;

    logic clock = 1'b0;
    logic reset_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clock = ~clock;

    seq_mult_booth_if #(.WIDTH(8)) if8 ();
    seq_mult_booth_if #(.WIDTH(4)) if4 ();

    seq_mult_booth #(.WIDTH(8)) dut8 (.clock(clock), .reset_n(reset_n), .bus(if8));
    seq_mult_booth #(.WIDTH(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(if4));

    typedef struct {
        logic        s;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic drive(input bit w4, input logic v, input logic [7:0] m,
                         input logic [7:0] q, input logic s);
        if (w4) begin
            if4.in_valid = v; if4.multiplicand = m[3:0]; if4.multiplier = q[3:0]; if4.is_signed = s;
        end else begin
            if8.in_valid = v; if8.multiplicand = m; if8.multiplier = q; if8.is_signed = s;
        end
    endtask

    function automatic logic get_ov(input bit w4);
        return w4 ? if4.out_valid : if8.out_valid;
    endfunction

    function automatic logic get_busy(input bit w4);
        return w4 ? if4.busy : if8.busy;
    endfunction

    function automatic logic [15:0] get_prod(input bit w4);
        return w4 ? {8'h00, if4.product} : if8.product;
    endfunction

    // Called #1 after an edge with the DUT idle and out_ready high.
    task automatic run_op(input bit w4, input logic [7:0] m, input logic [7:0] q,
                          input logic s, output logic [15:0] prod, output int lat,
                          output bit busy_ok);
        drive(w4, 1'b1, m, q, s);
        @(posedge clock); #1;
        drive(w4, 1'b0, m, q, s);
        lat = 0;
        busy_ok = get_busy(w4);
        while (lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (!get_busy(w4)) busy_ok = 1'b0;
            if (get_ov(w4)) break;
        end
        prod = get_prod(w4);
        @(posedge clock); #1;
    endtask

    vec_t        vecs[10];
    logic [15:0] prod;
    int          lat;
    bit          bok;
    int          a, b, e;

    initial begin
        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[4] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
        vecs[5] = '{1'b0, 8'h00, 8'hA5, 16'h0000};
        vecs[6] = '{1'b1, 8'h00, 8'hA5, 16'h0000};
        vecs[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[8] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[9] = '{1'b0, 8'hFD, 8'h05, 16'h04F1};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        if8.out_ready = 1'b1;
        if4.out_ready = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, if8.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
        check("rst_product", {16'd0, if8.product}, 32'd0);
        check("rst_busy", {31'd0, if8.busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_rst_in_ready", {31'd0, if8.in_ready}, 32'd1);

        // 8-bit vector table
        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, vecs[i].m, vecs[i].q, vecs[i].s, prod, lat, bok);
            check($sformatf("vec%0d_product", i), {16'd0, prod}, {16'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), lat, 32'd9);
            check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
        end

        // Backpressure then zero-bubble accept
        drive(1'b0, 1'b1, 8'h0F, 8'h11, 1'b0);
        if8.out_ready = 1'b0;
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 8'h0F, 8'h11, 1'b0);
        lat = 0;
        while (lat < 40 && !if8.out_valid) begin
            @(posedge clock); #1;
            lat++;
        end
        check("bp_latency", lat, 32'd9);
        drive(1'b0, 1'b1, 8'h03, 8'h05, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_product", {16'd0, if8.product}, 32'h00FF);
            check("bp_out_valid", {31'd0, if8.out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, if8.in_ready}, 32'd0);
            @(posedge clock); #1;
        end
        if8.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'd0, if8.in_ready}, 32'd1);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 8'h03, 8'h05, 1'b0);
        check("b2b_out_valid", {31'd0, if8.out_valid}, 32'd0);
        check("b2b_busy", {31'd0, if8.busy}, 32'd1);
        lat = 0;
        while (lat < 40 && !if8.out_valid) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b_latency", lat, 32'd9);
        check("b2b_product", {16'd0, if8.product}, 32'h000F);
        @(posedge clock); #1;

        // Asynchronous abort after four steps
        drive(1'b0, 1'b1, 8'h55, 8'h33, 1'b0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 8'h55, 8'h33, 1'b0);
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, if8.out_valid}, 32'd0);
        check("abort_product", {16'd0, if8.product}, 32'd0);
        check("abort_in_ready", {31'd0, if8.in_ready}, 32'd0);
        check("abort_busy", {31'd0, if8.busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("abort_release_in_ready", {31'd0, if8.in_ready}, 32'd1);
        @(posedge clock); #1;
        run_op(1'b0, 8'h07, 8'h06, 1'b0, prod, lat, bok);
        check("after_abort_product", {16'd0, prod}, 32'h002A);
        check("after_abort_latency", lat, 32'd9);

        // Exhaustive 4-bit sweep in both modes
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 16; m++) begin
                for (int q = 0; q < 16; q++) begin
                    a = (s == 1 && m >= 8) ? m - 16 : m;
                    b = (s == 1 && q >= 8) ? q - 16 : q;
                    e = (a * b) & 255;
                    run_op(1'b1, 8'(m), 8'(q), s[0], prod, lat, bok);
                    check($sformatf("w4_s%0d_m%0d_q%0d", s, m, q), {16'd0, prod}, e);
                    check($sformatf("w4_lat_s%0d_m%0d_q%0d", s, m, q), lat, 32'd5);
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_mult_booth.md
Name: seq_mult_booth

Overview:
Parametrised iterative multiplier. It computes the WIDTH x WIDTH -> 2*WIDTH product using radix-2 Booth recoding, one step per cycle. A per-operation is_signed mode selects two's-complement or unsigned operands. It uses valid/ready handshakes on input and output and supports back-to-back operations. It sits beside the datapath as a low-area multiply unit for control and DSP-lite paths.

Parameters:
WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
CNT_W, $clog2(WIDTH+2), step counter width; this is a localparam and is not overridable.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and mode are valid
in_ready  output  1  block can accept an operation this cycle
multiplicand  input  WIDTH  operand M
multiplier  input  WIDTH  operand Q
is_signed  input  1  1 = both operands are two's complement; 0 = both are unsigned
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts the product
product  output  2*WIDTH  result, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE, out_valid = 0, product = 0, counter = 0.
  - in_ready is forced to 0 while reset_n is low.
  - A reset during RUN or DONE aborts the operation. No out_valid is produced and the result is discarded.
- States:
  - IDLE: in_ready = 1.
    - On in_valid & in_ready: latch operands, go to RUN.
  - RUN: one Booth step per cycle; the counter decrements each step.
    - When the counter is 1, go to DONE.
  - DONE: out_valid = 1.
    - On out_ready, the result is consumed.
    - If in_valid is also high, accept the new operands and go to RUN.
    - Otherwise go to IDLE.
  - in_ready = (state == IDLE) | (state == DONE & out_ready). This gives zero-bubble back-to-back operation.
- Load (at the accepting edge):
  - M is extended to WIDTH+1 bits: sign-extended if is_signed, else zero-extended. Q is extended the same way.
  - The accumulator A (WIDTH+2 bits) is cleared, the Booth bit q_-1 is cleared, and the counter is set to WIDTH+1.
  - is_signed is captured. Inputs are ignored after acceptance.
- Step, based on {Q[0], q_-1}:
  - 10: A = A - sext(M).
  - 01: A = A + sext(M).
  - 00 or 11: no add.
  - Then arithmetic right-shift {A, Q, q_-1} by 1.
  - A is WIDTH+2 bits, so add/sub never overflows, including M = -2^(WIDTH-1) and M = 2^WIDTH - 1.
- Result:
  - After WIDTH+1 steps, product = low 2*WIDTH bits of {A, Q}.
  - This is exact for both modes: the full signed product fits 2*WIDTH bits, and the unsigned product is < 2^(2*WIDTH).
  - product is registered when entering DONE and holds until the next entry to DONE or reset.
- Latency and throughput:
  - out_valid rises after the (WIDTH+1)th rising edge following the accepting edge.
  - Throughput is one result per WIDTH+2 cycles with out_ready held high.
- Backpressure: while out_valid & !out_ready, product, out_valid and state are stable and in_ready = 0.
- in_valid while busy and not accepted has no effect. No buffering is provided; the producer holds its operands.

Decomposition:
- Package seq_mult_pkg contains:
  - the state enum (IDLE, RUN, DONE), one-hot encoded;
  - the Booth op enum (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB);
  - a function returning the Booth op from {Q[0], q_-1}.
- Sub-module seq_mult_booth_step is combinational and parametrised by WIDTH:
  - inputs: A, Q, q_-1, M_ext.
  - outputs: next A, Q, q_-1.
- The top level holds the FSM, counter, registers and handshake.

Test Plan:
1. WIDTH=8, is_signed=0, M=0xFF, Q=0xFF -> product=0xFE01; out_valid high exactly 9 edges after the accepting edge; busy high throughout.
2. is_signed=1: M=0x80, Q=0x80 -> 0x4000; M=0x80, Q=0x7F -> 0xC080; M=0xFF, Q=0xFF -> 0x0001.
3. is_signed=0: M=0x80, Q=0xFF -> 0x7F80; M=0x00, Q=0xA5 -> 0x0000 (same result in both modes).
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> product and out_valid stable and in_ready=0. Then raise out_ready with in_valid=1 (M=3, Q=5, unsigned) -> accepted the same edge; 0x000F valid 9 edges later with no IDLE cycle.
5. Reset mid-RUN: drop reset_n asynchronously after 4 steps -> out_valid=0, product=0, in_ready=0 immediately. After release, in_ready=1; the next op (M=7, Q=6) gives 0x002A.
6. WIDTH=4 regression: run an exhaustive 256-operand sweep in both modes against a reference model -> all match; latency is 5 edges.
